// File: rtl/puf_sched_pkg.sv
// Shared types and widths for the PUF job scheduler.
// Holds the FSM encoding, default requester count and the PUF data widths.
package puf_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int RSP_W       = 256;
    localparam int CHAL_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the search begins at ptr and wraps from N-1 back to 0.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int            pos_i;
    logic [IW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        pos_i = 0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            // ptr is always below N, so one subtraction is enough to wrap
            pos_i = int'(ptr) + i;
            if (pos_i >= N) begin
                pos_i = pos_i - N;
            end
            pos = IW'(pos_i);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/puf_job_scheduler.sv
// Shares one PUF core among NUM_REQ requesters, serving one job at a time in
// round-robin order. Each job ends on a rising edge of puf_done or on a timeout.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | waiting for any request; picks the winner and latches its challenge
//  ST_START   | one-cycle puf_start pulse; clears the timeout counter
//  ST_WAIT    | waiting for a fresh puf_done rising edge, or for the timeout
//  ST_DELIVER | rsp_valid pulse to the winner; pointer advances; grant drops
module puf_job_scheduler
    import puf_sched_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [8*NUM_REQ-1:0]  req_chal,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_err,
    output logic [RSP_W-1:0]      rsp_data,
    output logic                  busy,
    output logic                  puf_start,
    output logic [CHAL_W-1:0]     puf_challenge,
    input  logic                  puf_done,
    input  logic [RSP_W-1:0]      puf_response
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] win_idx_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          done_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               done_edge;
    logic               timeout_hit;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // A done level that was already high when WAIT began never forms an edge here.
    assign done_edge   = puf_done & ~done_q;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != ST_IDLE);
        puf_start = (state_q == ST_START);
        rsp_valid = '0;
        rsp_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_edge || timeout_hit) begin
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                rsp_valid = gnt;
                rsp_err   = err_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt           <= '0;
            rsp_data      <= '0;
            puf_challenge <= '0;
            ptr_q         <= '0;
            win_idx_q     <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= puf_done;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt           <= arb_gnt;
                        win_idx_q     <= arb_idx;
                        puf_challenge <= req_chal[int'(arb_idx)*CHAL_W +: CHAL_W];
                    end
                end
                ST_START: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
                ST_WAIT: begin
                    // completion outranks a timeout landing in the same cycle
                    if (done_edge) begin
                        rsp_data <= puf_response;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DELIVER: begin
                    gnt   <= '0;
                    ptr_q <= (win_idx_q == IDX_LAST) ? '0 : win_idx_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/puf_job_scheduler.md
PUF_JOB_SCHEDULER -- requirements
Module: puf_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one PUF core.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, max clk cycles waited for PUF completion.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge; one clock, reset asynchronous active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester level request, held until its rsp_valid.
REQ-006 SHALL have port req_chal  input  8*NUM_REQ  challenge of requester i in bits [8i+7:8i].
REQ-007 SHALL have port gnt  output  NUM_REQ  one-hot grant, high while that requester's job owns the PUF.
REQ-008 SHALL have port rsp_valid  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port rsp_err  output  1  high with rsp_valid when job ended by timeout.
REQ-010 SHALL have port rsp_data  output  256  registered response of last completed job.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port puf_start  output  1  one-cycle start pulse to PUF core.
REQ-013 SHALL have port puf_challenge  output  8  latched challenge, stable from START until return to IDLE.
REQ-014 SHALL have port puf_done  input  1  PUF core done flag (level).
REQ-015 SHALL have port puf_response  input  256  PUF core response.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, DELIVER.
REQ-017 IDLE: if any req bit high at edge N, SHALL select winner round-robin, latch its challenge, set gnt one-hot, go START (gnt and puf_challenge valid cycle N+1).
REQ-018 START: SHALL drive puf_start=1 for exactly this one cycle, clear timeout counter, go WAIT.
REQ-019 WAIT: completion SHALL be rising edge of puf_done (puf_done=1 and registered previous value=0); a level already high on entry SHALL NOT count.
REQ-020 WAIT: on completion at cycle M, SHALL capture puf_response sampled at M into rsp_data, go DELIVER.
REQ-021 WAIT: timeout counter SHALL increment each cycle; on reaching TIMEOUT_CYCLES-1 without completion SHALL load rsp_data=0, set error flag, go DELIVER; completion in the same cycle wins (no error).
REQ-022 DELIVER: SHALL pulse rsp_valid[winner] one cycle, rsp_err=error flag, update round-robin pointer to winner+1 modulo NUM_REQ, clear gnt, go IDLE.
REQ-023 Round-robin: search SHALL start at pointer and wrap; requester NUM_REQ-1 wraps to 0.
REQ-024 Requests arriving or changing while not IDLE SHALL be ignored until return to IDLE.
REQ-025 A granted requester dropping req mid-job SHALL NOT abort; result still delivered with rsp_valid.
REQ-026 Back-to-back: earliest next grant SHALL be the cycle after DELIVER (IDLE evaluates then).
REQ-027 rsp_data SHALL hold value until next DELIVER.
REQ-028 Timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES)) bits, never wrap.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, gnt=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, puf_start=0, puf_challenge=0, pointer=0, counter=0, done-edge register=0.
REQ-030 Reset mid-job SHALL discard the job with no rsp_valid; first post-reset grant SHALL favour requester 0.

Structure
REQ-031 State encoding, NUM_REQ default, response width 256 and challenge width 8 SHALL live in a shared package/header puf_sched_pkg.
REQ-032 Round-robin selection SHALL be one sub-module rr_arbiter (inputs req, pointer; outputs one-hot grant, index, any).

Verification
REQ-033 Single: req=4'b0010, req_chal[15:8]=8'hA5, puf_done rises 300 cycles after puf_start, puf_response=X -> gnt=4'b0010, puf_challenge=8'hA5, one puf_start pulse, rsp_valid=4'b0010 one cycle after done edge, rsp_data=X, rsp_err=0.
REQ-034 Contention: req=4'b1111 held, PUF model completes each job -> grant order 0,1,2,3,0, each rsp_valid to correct requester.
REQ-035 Timeout: TIMEOUT_CYCLES=50, puf_done held 0 -> rsp_valid[winner] and rsp_err=1 exactly 50 cycles after WAIT entry, rsp_data=0, next job then serviced.
REQ-036 Stale done: puf_done held 1 entering WAIT, falls, rises 20 cycles later -> completion only on that later rise.
REQ-037 Reset mid-WAIT: rst_n low 3 cycles -> all outputs 0 asynchronously, no rsp_valid; req=4'b1000 after reset -> grant 3 with pointer 0.
REQ-038 Drop request: granted requester deasserts req in WAIT -> job completes, rsp_valid still pulsed, pointer advances.
